// File: rtl/bldc_start_sequencer.sv
// BLDC start/stop sequencer: arm, duty ramp, run, controlled ramp-down, fault retry with backoff and lockout.
// Optional build macro START_SEQ_OVERCURRENT_LIMIT_EN adds overcurrent duty limiting in RAMP/RUN.
// Direction encoding: DIR_NONE=2'd0, DIR_CW=2'd1, DIR_CCW=2'd2.
module bldc_start_sequencer #(
  parameter int unsigned clk_freq_hz       = 54_000_000,
  parameter int unsigned pwm_counter_width = 11,
  parameter int unsigned ramp_step_us      = 100,
  parameter int unsigned duty_step         = 4,
  parameter int unsigned arm_us            = 50,
  parameter int unsigned backoff_ms        = 10,
  parameter int unsigned max_retries       = 3
) (
  input  logic                         sys_clk,
  input  logic                         reset_n,
  input  logic                         cmd_start,
  input  logic                         cmd_stop,
  input  logic                         cmd_clear,
  input  logic [1:0]                   direction_in,
  input  logic [pwm_counter_width-1:0] target_duty,
  input  logic                         fault_n,
  input  logic                         overcurrent_n,
  input  logic                         hall_error,
  output logic                         enable,
  output logic [1:0]                   direction,
  output logic [pwm_counter_width-1:0] pwm_duty,
  output logic                         at_target,
  output logic                         lockout,
  output logic [3:0]                   retry_count,
  output logic [2:0]                   seq_state
);

  localparam logic [1:0] DIR_NONE = 2'd0;
  localparam logic [1:0] DIR_CW   = 2'd1;
  localparam logic [1:0] DIR_CCW  = 2'd2;

  localparam int unsigned CYC_PER_US = clk_freq_hz / 1_000_000;
  localparam logic [31:0] TICK_CYC    = 32'(CYC_PER_US * ramp_step_us);
  localparam logic [31:0] ARM_CYC     = 32'(CYC_PER_US * arm_us);
  localparam logic [31:0] BACKOFF_CYC = 32'(CYC_PER_US * backoff_ms * 1000);
  localparam logic [pwm_counter_width-1:0] STEP = pwm_counter_width'(duty_step);
  localparam logic [3:0] MAX_RETRY = 4'(max_retries);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ARM       = 3'd1,
    S_RAMP      = 3'd2,
    S_RUN       = 3'd3,
    S_RAMP_DOWN = 3'd4,
    S_BACKOFF   = 3'd5,
    S_LOCKOUT   = 3'd6
  } state_t;

  state_t                         state_q, state_d;
  logic [31:0]                    tick_cnt_q, tick_cnt_d;
  logic [31:0]                    wait_cnt_q, wait_cnt_d;
  logic [pwm_counter_width-1:0]   duty_q, duty_d;
  logic [1:0]                     dir_sel_q, dir_sel_d;
  logic [1:0]                     next_dir_q, next_dir_d;
  logic                           rearm_q, rearm_d;
  logic [3:0]                     retry_q, retry_d;
  logic                           enable_q, at_target_q, lockout_q;
  logic [1:0]                     direction_q;
  logic                           active_d, wait_restart, enter_ramp;
  logic                           fault, tick, active_q;

  // Moves cur toward tgt by at most STEP without overshooting tgt.
  function automatic logic [pwm_counter_width-1:0] step_toward(
    input logic [pwm_counter_width-1:0] cur,
    input logic [pwm_counter_width-1:0] tgt
  );
    logic [pwm_counter_width-1:0] r;
    r = tgt;
    if (cur < tgt) begin
      if (tgt - cur > STEP) r = cur + STEP;
    end else if (cur > tgt) begin
      if (cur - tgt > STEP) r = cur - STEP;
    end
    return r;
  endfunction

  function automatic logic dir_valid(input logic [1:0] d);
    return (d == DIR_CW) || (d == DIR_CCW);
  endfunction

  assign fault    = !fault_n || hall_error;
  assign tick     = (tick_cnt_q == TICK_CYC - 32'd1);
  assign active_q = (state_q == S_ARM) || (state_q == S_RAMP) ||
                    (state_q == S_RUN) || (state_q == S_RAMP_DOWN);

`ifdef START_SEQ_OVERCURRENT_LIMIT_EN
  logic oc_active;
  assign oc_active = !overcurrent_n;
`else
  logic unused_overcurrent;
  assign unused_overcurrent = overcurrent_n;
`endif

  always_comb begin
    state_d      = state_q;
    duty_d       = duty_q;
    dir_sel_d    = dir_sel_q;
    next_dir_d   = next_dir_q;
    rearm_d      = rearm_q;
    retry_d      = retry_q;
    wait_restart = 1'b0;
    // Fault outranks every command in the powered states.
    if (active_q && fault) begin
      duty_d  = '0;
      rearm_d = 1'b0;
      retry_d = retry_q + 4'd1;
      state_d = (retry_q + 4'd1 == MAX_RETRY) ? S_LOCKOUT : S_BACKOFF;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (cmd_start && !cmd_stop && !fault && dir_valid(direction_in)) begin
            state_d   = S_ARM;
            dir_sel_d = direction_in;
            retry_d   = '0;
          end
        end
        S_ARM: begin
          if (cmd_stop) state_d = S_RAMP_DOWN;
          else if (wait_cnt_q == ARM_CYC - 32'd1) state_d = S_RAMP;
        end
        S_RAMP: begin
          if (cmd_stop) state_d = S_RAMP_DOWN;
`ifdef START_SEQ_OVERCURRENT_LIMIT_EN
          else if (oc_active) begin
            if (tick) duty_d = step_toward(duty_q, '0);
          end
`endif
          else if (duty_q == target_duty) state_d = S_RUN;
          else if (tick) begin
            duty_d = step_toward(duty_q, target_duty);
            if (duty_d == target_duty) state_d = S_RUN;
          end
        end
        S_RUN: begin
          if (cmd_stop) begin
            state_d = S_RAMP_DOWN;
            rearm_d = 1'b0;
          end
`ifdef START_SEQ_OVERCURRENT_LIMIT_EN
          else if (oc_active) begin
            if (tick) duty_d = step_toward(duty_q, '0);
          end
`endif
          else if (direction_in != dir_sel_q) begin
            state_d    = S_RAMP_DOWN;
            next_dir_d = direction_in;
            rearm_d    = dir_valid(direction_in);
          end else if (target_duty != duty_q) state_d = S_RAMP;
        end
        S_RAMP_DOWN: begin
          if (duty_q == '0) begin
            if (rearm_q) begin
              state_d   = S_ARM;
              dir_sel_d = next_dir_q;
              rearm_d   = 1'b0;
            end else state_d = S_IDLE;
          end else if (tick) duty_d = step_toward(duty_q, '0);
        end
        S_BACKOFF: begin
          if (cmd_stop) state_d = S_IDLE;
          else if (wait_cnt_q == BACKOFF_CYC - 32'd1) begin
            if (!fault) state_d = S_ARM;
            else wait_restart = 1'b1;
          end
        end
        S_LOCKOUT: begin
          if (cmd_clear) begin
            state_d = S_IDLE;
            retry_d = '0;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    enter_ramp = (state_d != state_q) &&
                 ((state_d == S_RAMP) || (state_d == S_RAMP_DOWN));
    tick_cnt_d = (enter_ramp || tick) ? 32'd0 : tick_cnt_q + 32'd1;

    if ((state_d != state_q) || wait_restart) wait_cnt_d = 32'd0;
    else if ((state_q == S_ARM) || (state_q == S_BACKOFF)) wait_cnt_d = wait_cnt_q + 32'd1;
    else wait_cnt_d = wait_cnt_q;

    active_d = (state_d == S_ARM) || (state_d == S_RAMP) ||
               (state_d == S_RUN) || (state_d == S_RAMP_DOWN);
  end

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      tick_cnt_q  <= '0;
      wait_cnt_q  <= '0;
      duty_q      <= '0;
      dir_sel_q   <= DIR_NONE;
      next_dir_q  <= DIR_NONE;
      rearm_q     <= 1'b0;
      retry_q     <= '0;
      enable_q    <= 1'b0;
      direction_q <= DIR_NONE;
      at_target_q <= 1'b0;
      lockout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      tick_cnt_q  <= tick_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
      duty_q      <= duty_d;
      dir_sel_q   <= dir_sel_d;
      next_dir_q  <= next_dir_d;
      rearm_q     <= rearm_d;
      retry_q     <= retry_d;
      enable_q    <= active_d;
      direction_q <= active_d ? dir_sel_d : DIR_NONE;
      at_target_q <= (state_d == S_RUN);
      lockout_q   <= (state_d == S_LOCKOUT);
    end
  end

  assign enable      = enable_q;
  assign direction   = direction_q;
  assign pwm_duty    = duty_q;
  assign at_target   = at_target_q;
  assign lockout     = lockout_q;
  assign retry_count = retry_q;
  assign seq_state   = state_q;

endmodule

// File: tb/tb_bldc_start_sequencer.sv
// Self-checking bench for bldc_start_sequencer: directed scenarios plus randomized traffic against a cycle model.
module tb_bldc_start_sequencer;

  localparam int W      = 8;
  localparam int T_CYC  = 3;     // ramp tick period in cycles (1 MHz clock, 3 us)
  localparam int A_CYC  = 4;     // arm wait in cycles
  localparam int B_CYC  = 1000;  // backoff in cycles (1 ms)
  localparam int STEP   = 4;
  localparam int MAXR   = 3;
  localparam logic [1:0] DIR_NONE = 2'd0;
  localparam logic [1:0] DIR_CW   = 2'd1;
  localparam logic [1:0] DIR_CCW  = 2'd2;
  localparam int M_IDLE = 0, M_ARM = 1, M_RAMP = 2, M_RUN = 3, M_DOWN = 4, M_BACK = 5, M_LOCK = 6;

  logic         sys_clk, reset_n, cmd_start, cmd_stop, cmd_clear;
  logic [1:0]   direction_in, direction;
  logic [W-1:0] target_duty, pwm_duty;
  logic         fault_n, overcurrent_n, hall_error;
  logic         enable, at_target, lockout;
  logic [3:0]   retry_count;
  logic [2:0]   seq_state;
  logic [19:0]  dut_vec;

  int n_tests = 0;
  int n_fail  = 0;
  logic chk_on;
  int dq[$];

  // Reference model state
  int m_st, m_duty, m_dir, m_ndir, m_rearm, m_retry, m_age, m_phase;

  bldc_start_sequencer #(
    .clk_freq_hz(1_000_000), .pwm_counter_width(W), .ramp_step_us(T_CYC),
    .duty_step(STEP), .arm_us(A_CYC), .backoff_ms(1), .max_retries(MAXR)
  ) dut (
    .sys_clk(sys_clk), .reset_n(reset_n), .cmd_start(cmd_start), .cmd_stop(cmd_stop),
    .cmd_clear(cmd_clear), .direction_in(direction_in), .target_duty(target_duty),
    .fault_n(fault_n), .overcurrent_n(overcurrent_n), .hall_error(hall_error),
    .enable(enable), .direction(direction), .pwm_duty(pwm_duty), .at_target(at_target),
    .lockout(lockout), .retry_count(retry_count), .seq_state(seq_state)
  );

  assign dut_vec = {seq_state, enable, direction, pwm_duty, at_target, lockout, retry_count};

  always #5 sys_clk = ~sys_clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [19:0] model_vec();
    logic act;
    act = (m_st >= M_ARM) && (m_st <= M_DOWN);
    return {3'(m_st), act, act ? 2'(m_dir) : 2'd0, 8'(m_duty),
            (m_st == M_RUN), (m_st == M_LOCK), 4'(m_retry)};
  endfunction

  task automatic model_step();
    int ns, nd, tgt;
    logic flt, tk;
    ns  = m_st;
    nd  = m_duty;
    tgt = int'(target_duty);
    flt = !fault_n || hall_error;
    tk  = (m_phase % T_CYC) == T_CYC - 1;
    if ((m_st >= M_ARM) && (m_st <= M_DOWN) && flt) begin
      m_retry = m_retry + 1;
      nd = 0;
      m_rearm = 0;
      ns = (m_retry == MAXR) ? M_LOCK : M_BACK;
    end else begin
      case (m_st)
        M_IDLE: if (cmd_start && !cmd_stop && !flt &&
                    (direction_in == DIR_CW || direction_in == DIR_CCW)) begin
          ns = M_ARM; m_dir = int'(direction_in); m_retry = 0;
        end
        M_ARM: if (cmd_stop) ns = M_DOWN;
               else if (m_age + 1 == A_CYC) ns = M_RAMP;
        M_RAMP: if (cmd_stop) ns = M_DOWN;
                else if (m_duty == tgt) ns = M_RUN;
                else if (tk) begin
                  nd = (tgt > m_duty) ? ((m_duty + STEP > tgt) ? tgt : m_duty + STEP)
                                      : ((m_duty - STEP < tgt) ? tgt : m_duty - STEP);
                  if (nd == tgt) ns = M_RUN;
                end
        M_RUN: if (cmd_stop) begin ns = M_DOWN; m_rearm = 0; end
               else if (int'(direction_in) != m_dir) begin
                 ns = M_DOWN; m_ndir = int'(direction_in);
                 m_rearm = (direction_in == DIR_CW || direction_in == DIR_CCW) ? 1 : 0;
               end else if (tgt != m_duty) ns = M_RAMP;
        M_DOWN: if (m_duty == 0) begin
                  if (m_rearm != 0) begin ns = M_ARM; m_dir = m_ndir; m_rearm = 0; end
                  else ns = M_IDLE;
                end else if (tk) nd = (m_duty - STEP < 0) ? 0 : m_duty - STEP;
        M_BACK: if (cmd_stop) ns = M_IDLE;
                else if (((m_age + 1) % B_CYC) == 0 && !flt) ns = M_ARM;
        M_LOCK: if (cmd_clear) begin ns = M_IDLE; m_retry = 0; end
        default: ns = M_IDLE;
      endcase
    end
    m_phase = (ns != m_st && (ns == M_RAMP || ns == M_DOWN)) ? 0 : m_phase + 1;
    m_age   = (ns != m_st) ? 0 : m_age + 1;
    m_st    = ns;
    m_duty  = nd;
  endtask

  always @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      m_st = M_IDLE; m_duty = 0; m_dir = 0; m_ndir = 0;
      m_rearm = 0; m_retry = 0; m_age = 0; m_phase = 0;
    end else model_step();
  end

  always @(negedge sys_clk) if (chk_on) check_eq("cycle", 32'(dut_vec), 32'(model_vec()));

  // Records each new pwm_duty value and the ARM cycle count until seq_state reaches st.
  task automatic trace_until(input string tag, input logic [2:0] st, input int budget, output int arm_cyc);
    logic [W-1:0] prev;
    int n;
    dq.delete();
    prev = pwm_duty;
    arm_cyc = (seq_state == 3'd1) ? 1 : 0;
    n = 0;
    while (seq_state != st && n < budget) begin
      @(negedge sys_clk);
      n++;
      if (seq_state == 3'd1) arm_cyc++;
      if (pwm_duty != prev) begin
        dq.push_back(int'(pwm_duty));
        prev = pwm_duty;
      end
    end
    check_eq(tag, 32'(seq_state), 32'(st));
  endtask

  task automatic check_seq(input string tag, input int exp[$]);
    check_eq({tag, "_len"}, 32'(dq.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size() && i < dq.size(); i++)
      check_eq(tag, 32'(dq[i]), 32'(exp[i]));
  endtask

  task automatic pulse_start();
    cmd_start = 1'b1; @(negedge sys_clk); cmd_start = 1'b0;
  endtask

  task automatic pulse_fault();
    fault_n = 1'b0; @(negedge sys_clk); fault_n = 1'b1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int arm;
    sys_clk = 1'b0; reset_n = 1'b0; chk_on = 1'b0;
    cmd_start = 1'b0; cmd_stop = 1'b0; cmd_clear = 1'b0;
    direction_in = DIR_NONE; target_duty = '0;
    fault_n = 1'b1; overcurrent_n = 1'b1; hall_error = 1'b0;
    repeat (3) @(negedge sys_clk);
    check_eq("reset_outputs", 32'(dut_vec), 32'd0);
    reset_n = 1'b1;
    chk_on = 1'b1;
    @(negedge sys_clk);

    // Start and stop together in IDLE, and start with no direction, are both ignored.
    direction_in = DIR_CW; cmd_start = 1'b1; cmd_stop = 1'b1;
    @(negedge sys_clk);
    cmd_start = 1'b0; cmd_stop = 1'b0;
    check_eq("start_stop_idle", 32'(seq_state), 32'd0);
    direction_in = DIR_NONE;
    pulse_start();
    check_eq("start_dir_none", 32'(seq_state), 32'd0);

    // Ramp up to 20.
    direction_in = DIR_CW; target_duty = 8'd20;
    pulse_start();
    check_eq("arm_enable", 32'(enable), 32'd1);
    trace_until("rampup_run", 3'd3, 200, arm);
    check_eq("rampup_arm_cycles", 32'(arm), 32'(A_CYC));
    check_seq("rampup_duty", '{4, 8, 12, 16, 20});
    check_eq("rampup_at_target", 32'(at_target), 32'd1);
    check_eq("rampup_dir", 32'(direction), 32'(DIR_CW));

    // Controlled stop.
    cmd_stop = 1'b1; @(negedge sys_clk); cmd_stop = 1'b0;
    trace_until("stop_idle", 3'd0, 200, arm);
    check_seq("stop_duty", '{16, 12, 8, 4, 0});
    check_eq("stop_enable", 32'(enable), 32'd0);
    check_eq("stop_dir", 32'(direction), 32'(DIR_NONE));

    // Saturation at target in both directions.
    target_duty = 8'd10;
    pulse_start();
    trace_until("sat_run", 3'd3, 200, arm);
    check_seq("sat_up_duty", '{4, 8, 10});
    target_duty = 8'd2;
    @(negedge sys_clk);
    trace_until("sat_down_run", 3'd3, 200, arm);
    check_seq("sat_down_duty", '{6, 2});

    // Direction change in RUN.
    direction_in = DIR_CCW;
    @(negedge sys_clk);
    check_eq("dirchg_rampdown", 32'(seq_state), 32'd4);
    trace_until("dirchg_run", 3'd3, 200, arm);
    check_seq("dirchg_duty", '{0, 2});
    check_eq("dirchg_arm_cycles", 32'(arm), 32'(A_CYC));
    check_eq("dirchg_dir", 32'(direction), 32'(DIR_CCW));

    // Retries leading to lockout.
    for (int k = 1; k <= MAXR; k++) begin
      pulse_fault();
      check_eq("fault_state", 32'(seq_state), (k == MAXR) ? 32'd6 : 32'd5);
      check_eq("fault_retry", 32'(retry_count), 32'(k));
      check_eq("fault_off", 32'({enable, pwm_duty}), 32'd0);
      if (k < MAXR) trace_until("retry_run", 3'd3, B_CYC + 200, arm);
    end
    check_eq("lockout_flag", 32'(lockout), 32'd1);
    pulse_start();
    check_eq("lockout_ignores_start", 32'(seq_state), 32'd6);
    cmd_clear = 1'b1; @(negedge sys_clk); cmd_clear = 1'b0;
    check_eq("clear_idle", 32'(seq_state), 32'd0);
    check_eq("clear_retry", 32'(retry_count), 32'd0);

    // Asynchronous reset mid-ramp.
    target_duty = 8'd40;
    pulse_start();
    for (int i = 0; i < 200 && pwm_duty != 8'd8; i++) @(negedge sys_clk);
    check_eq("ramp_mid_duty", 32'(pwm_duty), 32'd8);
    check_eq("ramp_mid_state", 32'(seq_state), 32'd2);
    #2 reset_n = 1'b0;
    #1 check_eq("async_reset", 32'(dut_vec), 32'd0);
    @(negedge sys_clk);
    reset_n = 1'b1;

    // Randomized traffic checked every cycle against the model.
    for (int c = 0; c < 20000; c++) begin
      cmd_start = ($urandom_range(7) == 0);
      cmd_stop  = ($urandom_range(59) == 0);
      cmd_clear = ($urandom_range(39) == 0);
      if ($urandom_range(79) == 0) direction_in = 2'($urandom_range(2));
      if ($urandom_range(49) == 0) target_duty = 8'($urandom_range(40));
      fault_n       = !($urandom_range(299) == 0);
      hall_error    = ($urandom_range(599) == 0);
      overcurrent_n = ($urandom_range(3) != 0);
      @(negedge sys_clk);
    end

    chk_on = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/bldc_start_sequencer.md
BLDC_START_SEQUENCER -- requirements
Module: bldc_start_sequencer

Interface
REQ-001 Parameter clk_freq_hz, default 54_000_000: sys_clk frequency.
REQ-002 Parameter pwm_counter_width, default 11: duty word width, matching the driver pwm_duty input.
REQ-003 Parameter ramp_step_us, default 100: interval between ramp steps, in µs.
REQ-004 Parameter duty_step, default 4: duty change per ramp step, in counts.
REQ-005 Parameter arm_us, default 50: gate-settle wait in ARM, in µs.
REQ-006 Parameter backoff_ms, default 10: wait after a fault before retry, in ms.
REQ-007 Parameter max_retries, default 3: number of faults that causes lockout; retry_count is 4 bits wide.
REQ-008 Port sys_clk, input, 1 bit: the only clock; all logic is on its rising edge.
REQ-009 Port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-010 Port cmd_start, input, 1 bit: one-cycle start pulse.
REQ-011 Port cmd_stop, input, 1 bit: one-cycle controlled-stop pulse.
REQ-012 Port cmd_clear, input, 1 bit: one-cycle pulse that clears lockout.
REQ-013 Port direction_in, input, rotation_direction_t: requested direction.
REQ-014 Port target_duty, input, pwm_counter_width bits: requested steady-state duty.
REQ-015 Port fault_n, input, 1 bit: gate driver fault, active low.
REQ-016 Port overcurrent_n, input, 1 bit: overcurrent warning, active low.
REQ-017 Port hall_error, input, 1 bit: invalid hall code.
REQ-018 Port enable, output, 1 bit: driver enable.
REQ-019 Port direction, output, rotation_direction_t: driver direction.
REQ-020 Port pwm_duty, output, pwm_counter_width bits: driver duty.
REQ-021 Port at_target, output, 1 bit: high in RUN.
REQ-022 Port lockout, output, 1 bit: high in LOCKOUT.
REQ-023 Port retry_count, output, 4 bits: faults since the last accepted start.
REQ-024 Port seq_state, output, 3 bits: encoded state, IDLE=0, ARM=1, RAMP=2, RUN=3, RAMP_DOWN=4, BACKOFF=5, LOCKOUT=6.

Function
REQ-025 A free-running tick SHALL pulse once every clk_freq_hz/1_000_000*ramp_step_us cycles; it restarts from zero on every entry to RAMP or RAMP_DOWN.
REQ-026 In IDLE, with outputs enable=0 and pwm_duty=0: cmd_start with direction_in!=DIR_NONE and no fault SHALL latch direction, clear retry_count and go to ARM; cmd_start with direction_in=DIR_NONE SHALL be ignored.
REQ-027 In ARM: enable=1 and pwm_duty=0; after arm_us elapses the block SHALL go to RAMP.
REQ-028 In RAMP, on each tick: pwm_duty SHALL move toward target_duty by duty_step, saturating exactly at target_duty with no overshoot, in either direction; on equality the block SHALL go to RUN.
REQ-029 In RUN: a change of target_duty SHALL return to RAMP; a change of direction_in SHALL go to RAMP_DOWN and then re-ARM with the new direction, unless the new direction is DIR_NONE, which goes to IDLE.
REQ-030 cmd_stop in ARM, RAMP or RUN SHALL go to RAMP_DOWN, which decrements pwm_duty by duty_step per tick, saturating at 0.
REQ-031 When RAMP_DOWN reaches duty 0, the next cycle SHALL drive enable=0 and direction=DIR_NONE and enter IDLE.
REQ-032 fault_n=0 or hall_error=1 in ARM, RAMP, RUN or RAMP_DOWN SHALL, on the next cycle, force pwm_duty=0, enable=0 and increment retry_count.
REQ-033 After a fault (REQ-032), the block SHALL go to LOCKOUT if the new retry_count equals max_retries, otherwise to BACKOFF.
REQ-034 In BACKOFF: outputs stay off for backoff_ms, then the block SHALL go to ARM if fault_n=1 and hall_error=0; otherwise BACKOFF restarts.
REQ-035 cmd_stop in BACKOFF SHALL go to IDLE.
REQ-036 LOCKOUT SHALL hold all outputs off and ignore cmd_start; cmd_clear SHALL go to IDLE and clear retry_count.
REQ-037 Simultaneous events SHALL be resolved with priority fault, then cmd_stop, then cmd_start, then target or direction change.
REQ-038 All outputs SHALL be registered; each command SHALL take effect on outputs one cycle after it is sampled.

Reset
REQ-039 reset_n=0 SHALL, asynchronously: set state IDLE, enable=0, direction=DIR_NONE, pwm_duty=0, retry_count=0, at_target=0, lockout=0, and clear all timers.
REQ-040 Reset asserted mid-operation SHALL force outputs off immediately, without a ramp-down.

Configuration
REQ-041 Macro START_SEQ_OVERCURRENT_LIMIT_EN, when defined: overcurrent_n=0 in RAMP or RUN SHALL, per tick, decrease pwm_duty by duty_step (floor 0) and stop any increase.
REQ-042 With START_SEQ_OVERCURRENT_LIMIT_EN defined: after overcurrent_n returns to 1, a block in RUN with pwm_duty below target_duty SHALL go to RAMP.
REQ-043 Without START_SEQ_OVERCURRENT_LIMIT_EN: overcurrent_n SHALL be ignored entirely.

Verification
REQ-044 Scenario, ramp up: duty_step=4, target_duty=20, cmd_start with DIR_CW -> ARM for arm_us, then pwm_duty 4, 8, 12, 16, 20 on consecutive ticks, then RUN with at_target=1.
REQ-045 Scenario, stop: in RUN at duty 20, pulse cmd_stop -> duty 16, 12, 8, 4, 0 per tick, then enable=0, direction=DIR_NONE and IDLE.
REQ-046 Scenario, retries: fault_n=0 for 1 cycle in RUN, three times with max_retries=3 -> BACKOFF, BACKOFF, then LOCKOUT with retry_count=3; cmd_start is ignored; cmd_clear -> IDLE with retry_count=0.
REQ-047 Scenario, saturation: target_duty=10, duty_step=4 -> duty 4, 8, 10 with no overshoot; then retarget to 2 -> duty 6, 2.
REQ-048 Scenario, direction change: in RUN, change direction_in from DIR_CW to DIR_CCW -> ramp to 0, ARM with direction=DIR_CCW, then ramp to target.
REQ-049 Scenario, simultaneous events and reset: cmd_start and cmd_stop in the same cycle in IDLE -> stays IDLE; reset_n pulse low in RAMP -> all outputs 0 immediately.
